// File: rtl/voice_allocator.sv
// voice_allocator: assigns note-on/note-off commands to eight voice slots.
// Each command is scanned one voice per cycle, then committed in one cycle.
module voice_allocator #(
    parameter int unsigned NUM_VOICES = 8,
    parameter int unsigned D_W        = 16,
    parameter int unsigned NOTE_W     = 7,
    parameter int unsigned AGE_W      = 8
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_on,
    input  logic [NOTE_W-1:0]         cmd_note,
    input  logic [D_W-1:0]            cmd_div,
    output logic [NUM_VOICES*D_W-1:0] voice_div,
    output logic [NUM_VOICES-1:0]     voice_gate,
    output logic                      steal_pulse,
    output logic                      busy
);

    localparam int unsigned IDX_W = $clog2(NUM_VOICES);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    on_q, on_d;
    logic [NOTE_W-1:0]       lnote_q, lnote_d;
    logic [D_W-1:0]          ldiv_q, ldiv_d;
    logic                    match_vld_q, match_vld_d;
    logic [IDX_W-1:0]        match_idx_q, match_idx_d;
    logic                    free_vld_q, free_vld_d;
    logic [IDX_W-1:0]        free_idx_q, free_idx_d;
    logic                    old_vld_q, old_vld_d;
    logic [IDX_W-1:0]        old_idx_q, old_idx_d;
    logic [AGE_W-1:0]        old_age_q, old_age_d;
    logic [D_W-1:0]          div_q [NUM_VOICES];
    logic [D_W-1:0]          div_d [NUM_VOICES];
    logic [NOTE_W-1:0]       note_q [NUM_VOICES];
    logic [NOTE_W-1:0]       note_d [NUM_VOICES];
    logic [AGE_W-1:0]        age_q [NUM_VOICES];
    logic [AGE_W-1:0]        age_d [NUM_VOICES];
    logic [NUM_VOICES-1:0]   gate_q, gate_d;
    logic                    ready_q, ready_d;
    logic                    busy_q, busy_d;
    logic                    steal_q, steal_d;
    logic [IDX_W-1:0]        tgt;
    logic                    tgt_steal;

    // Next-state, scan tracking and commit of voice registers
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        on_d        = on_q;
        lnote_d     = lnote_q;
        ldiv_d      = ldiv_q;
        match_vld_d = match_vld_q;
        match_idx_d = match_idx_q;
        free_vld_d  = free_vld_q;
        free_idx_d  = free_idx_q;
        old_vld_d   = old_vld_q;
        old_idx_d   = old_idx_q;
        old_age_d   = old_age_q;
        div_d       = div_q;
        note_d      = note_q;
        age_d       = age_q;
        gate_d      = gate_q;
        steal_d     = 1'b0;
        tgt         = '0;
        tgt_steal   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && ready_q) begin
                    on_d        = cmd_on;
                    lnote_d     = cmd_note;
                    ldiv_d      = cmd_div;
                    match_vld_d = 1'b0;
                    match_idx_d = '0;
                    free_vld_d  = 1'b0;
                    free_idx_d  = '0;
                    old_vld_d   = 1'b0;
                    old_idx_d   = '0;
                    old_age_d   = '0;
                    idx_d       = '0;
                    state_d     = S_SCAN;
                end
            end
            S_SCAN: begin
                if (gate_q[idx_q] && note_q[idx_q] == lnote_q && !match_vld_q) begin
                    match_vld_d = 1'b1;
                    match_idx_d = idx_q;
                end
                if (!gate_q[idx_q] && !free_vld_q) begin
                    free_vld_d = 1'b1;
                    free_idx_d = idx_q;
                end
                // strict compare keeps the lowest index on equal ages
                if (gate_q[idx_q] && (!old_vld_q || age_q[idx_q] > old_age_q)) begin
                    old_vld_d = 1'b1;
                    old_idx_d = idx_q;
                    old_age_d = age_q[idx_q];
                end
                if (idx_q == IDX_W'(NUM_VOICES - 1)) begin
                    state_d = S_COMMIT;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_COMMIT: begin
                state_d = S_IDLE;
                if (on_q) begin
                    if (match_vld_q) begin
                        tgt = match_idx_q;
                    end else if (free_vld_q) begin
                        tgt = free_idx_q;
                    end else begin
                        tgt       = old_idx_q;
                        tgt_steal = 1'b1;
                    end
                    steal_d = tgt_steal;
                    for (int v = 0; v < int'(NUM_VOICES); v++) begin
                        if (IDX_W'(v) == tgt) begin
                            div_d[v]  = ldiv_q;
                            note_d[v] = lnote_q;
                            gate_d[v] = 1'b1;
                            age_d[v]  = '0;
                        end else if (gate_q[v] && age_q[v] != {AGE_W{1'b1}}) begin
                            age_d[v] = age_q[v] + AGE_W'(1);
                        end
                    end
                end else if (match_vld_q) begin
                    gate_d[match_idx_q] = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
    end

    // State and datapath registers
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            on_q        <= 1'b0;
            lnote_q     <= '0;
            ldiv_q      <= '0;
            match_vld_q <= 1'b0;
            match_idx_q <= '0;
            free_vld_q  <= 1'b0;
            free_idx_q  <= '0;
            old_vld_q   <= 1'b0;
            old_idx_q   <= '0;
            old_age_q   <= '0;
            for (int v = 0; v < int'(NUM_VOICES); v++) begin
                div_q[v]  <= '0;
                note_q[v] <= '0;
                age_q[v]  <= '0;
            end
            gate_q  <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            steal_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            on_q        <= on_d;
            lnote_q     <= lnote_d;
            ldiv_q      <= ldiv_d;
            match_vld_q <= match_vld_d;
            match_idx_q <= match_idx_d;
            free_vld_q  <= free_vld_d;
            free_idx_q  <= free_idx_d;
            old_vld_q   <= old_vld_d;
            old_idx_q   <= old_idx_d;
            old_age_q   <= old_age_d;
            div_q       <= div_d;
            note_q      <= note_d;
            age_q       <= age_d;
            gate_q      <= gate_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            steal_q     <= steal_d;
        end
    end

    // Pack dividers for the oscillator bank
    for (genvar g = 0; g < int'(NUM_VOICES); g++) begin : g_pack
        assign voice_div[g*D_W +: D_W] = div_q[g];
    end

    assign voice_gate  = gate_q;
    assign cmd_ready   = ready_q;
    assign busy        = busy_q;
    assign steal_pulse = steal_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Testbench for voice_allocator: directed commands, expected outcome queued
// at accept time, checked by a monitor when the allocator returns to idle.
module tb_voice_allocator;

    logic         sys_clk = 1'b0;
    logic         sys_rst = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic         cmd_on = 1'b0;
    logic [6:0]   cmd_note = '0;
    logic [15:0]  cmd_div = '0;
    logic [127:0] voice_div;
    logic [7:0]   voice_gate;
    logic         steal_pulse;
    logic         busy;

    voice_allocator dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_on      (cmd_on),
        .cmd_note    (cmd_note),
        .cmd_div     (cmd_div),
        .voice_div   (voice_div),
        .voice_gate  (voice_gate),
        .steal_pulse (steal_pulse),
        .busy        (busy)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [127:0] div;
        logic [7:0]   gate;
        logic         steal;
        int           acc;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [15:0] exp_div [8];
    logic [7:0]  exp_gate = '0;
    logic        prev_busy = 1'b0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] pack_div();
        logic [127:0] r;
        for (int i = 0; i < 8; i++) r[i*16 +: 16] = exp_div[i];
        return r;
    endfunction

    // Issue one command; expectation is queued unless this command will be aborted
    task automatic send(input logic on, input logic [6:0] note, input logic [15:0] div,
                        input logic steal, input logic push);
        int   n;
        exp_t e;
        @(negedge sys_clk);
        cmd_valid = 1'b1;
        cmd_on    = on;
        cmd_note  = note;
        cmd_div   = div;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge sys_clk);
            n++;
        end
        if (!cmd_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: cmd_ready got 0 expected 1 note=%0d", note);
        end
        @(posedge sys_clk);
        #1;
        if (push) begin
            e.div   = pack_div();
            e.gate  = exp_gate;
            e.steal = steal;
            e.acc   = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic drop_valid();
        @(negedge sys_clk);
        cmd_valid = 1'b0;
    endtask

    // Monitor: a busy->idle transition marks a completed command
    initial begin
        exp_t e;
        forever begin
            @(negedge sys_clk);
            if (sys_rst) begin
                prev_busy = 1'b0;
            end else begin
                if (prev_busy && !busy) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_commit: got commit expected none");
                    end else begin
                        e = sb.pop_front();
                        chk("voice_div", voice_div, e.div);
                        chk("voice_gate", 128'(voice_gate), 128'(e.gate));
                        chk("steal_pulse", 128'(steal_pulse), 128'(e.steal));
                        chk("latency", 128'(cyc - e.acc), 128'(9));
                        chk("ready_after", 128'(cmd_ready), 128'(1));
                    end
                end else if (steal_pulse) begin
                    chk("steal_spurious", 128'(steal_pulse), 128'(0));
                end
                prev_busy = busy;
            end
        end
    end

    initial begin
        int n;
        for (int i = 0; i < 8; i++) exp_div[i] = '0;

        // reset state
        #1 sys_rst = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_ready", 128'(cmd_ready), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_gate", 128'(voice_gate), 128'(0));
        chk("rst_div", voice_div, 128'(0));
        chk("rst_steal", 128'(steal_pulse), 128'(0));
        @(negedge sys_clk);
        sys_rst = 1'b0;
        @(posedge sys_clk);
        #1;
        chk("ready_after_release", 128'(cmd_ready), 128'(1));

        // fill all voices back to back
        for (int i = 0; i < 8; i++) begin
            exp_div[i]  = 16'h0100 + 16'(i);
            exp_gate[i] = 1'b1;
            send(1'b1, 7'(60 + i), 16'h0100 + 16'(i), 1'b0, 1'b1);
        end
        drop_valid();

        // steal oldest (voice 0)
        exp_div[0] = 16'h0A00;
        send(1'b1, 7'd70, 16'h0A00, 1'b1, 1'b1);
        drop_valid();

        // note-off 63 then refill lowest free voice 3
        exp_gate[3] = 1'b0;
        send(1'b0, 7'd63, 16'h0000, 1'b0, 1'b1);
        exp_gate[3] = 1'b1;
        exp_div[3]  = 16'h0200;
        send(1'b1, 7'd80, 16'h0200, 1'b0, 1'b1);
        drop_valid();

        // retrigger held note 65 on voice 5
        exp_div[5] = 16'h0555;
        send(1'b1, 7'd65, 16'h0555, 1'b0, 1'b1);
        drop_valid();

        // note-off of an absent note
        send(1'b0, 7'd99, 16'h0000, 1'b0, 1'b1);
        drop_valid();

        // voice 1 is now the oldest (age 9): a new note steals it
        exp_div[1] = 16'h0900;
        send(1'b1, 7'd90, 16'h0900, 1'b1, 1'b1);
        drop_valid();

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge sys_clk);
            n++;
        end

        // reset during scan aborts the command
        send(1'b1, 7'd50, 16'h0777, 1'b0, 1'b0);
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst   = 1'b1;
        cmd_valid = 1'b0;
        #1;
        chk("midrst_gate", 128'(voice_gate), 128'(0));
        chk("midrst_div", voice_div, 128'(0));
        chk("midrst_busy", 128'(busy), 128'(0));
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        for (int i = 0; i < 8; i++) exp_div[i] = '0;
        exp_gate   = 8'h01;
        exp_div[0] = 16'h0123;
        send(1'b1, 7'd61, 16'h0123, 1'b0, 1'b1);
        drop_valid();

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge sys_clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: pending got %0d expected 0", sb.size());
        end
        repeat (3) @(negedge sys_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Polyphonic voice scheduler between the SPI/MIDI command front end and the eight voice oscillators. It accepts note-on/note-off commands through a valid/ready handshake and assigns each note-on to a voice: retrigger of a matching held note first, then lowest free voice, then steal of the oldest held voice. It owns the per-voice divider registers and gate bits consumed by the oscillator bank.

## Interface
- NUM_VOICES, 8, number of voice slots (index width 3)
- D_W, 16, divider width
- NOTE_W, 7, note identifier width
- AGE_W, 8, per-voice age counter width (saturating)

- sys_clk  in  1  system clock; all logic on rising edge
- sys_rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  allocator can accept a command
- cmd_on  in  1  1 = note-on, 0 = note-off
- cmd_note  in  NOTE_W  note identifier
- cmd_div  in  D_W  divider for note-on (ignored for note-off)
- voice_div  out  NUM_VOICES*D_W  packed dividers, voice n at [n*D_W +: D_W]
- voice_gate  out  NUM_VOICES  gate per voice, 1 = sounding
- steal_pulse  out  1  one-cycle strobe when a note-on evicted a held voice
- busy  out  1  high whenever state is not IDLE

## Operation
- Per voice: div register, note register, gate bit, AGE_W age counter.
- FSM: IDLE -> SCAN -> COMMIT -> IDLE.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch cmd_on/cmd_note/cmd_div, clear scan results, index=0, go SCAN.
- SCAN: examine one voice per cycle, index 0..NUM_VOICES-1; go COMMIT after the last index. Tracks:
  - match: first voice with gate=1 and note==latched note;
  - free: first voice with gate=0;
  - oldest: gated voice with largest age; ties go to lowest index.
- COMMIT, note-on: target = match, else free, else oldest. Target gets div=latched div, note=latched note, gate=1, age=0. Every other gated voice: age+1, saturating at 2^AGE_W-1. steal_pulse=1 only when target came from oldest.
- COMMIT, note-off: if match exists, clear its gate; div, note, age retained. No match: no state change.
- cmd_div=0 on note-on is written as is; gate still set.
- Duplicate held notes cannot arise because note-on retriggers the match.
- Ages of ungated voices do not change.

## Timing
- Reset (async assert): state IDLE; all voice_div=0, note=0, voice_gate=0, ages=0; steal_pulse=0, busy=0. cmd_ready=0 while sys_rst is high and 1 from the first edge after release.
- Accept edge E0. SCAN occupies E0..E8 (8 cycles). COMMIT registers update at edge E9. State is IDLE and cmd_ready=1 after E9.
- Latency: outputs reflect the command 9 cycles after the accept edge. Throughput: one command per 9 cycles.
- cmd_ready=0 in SCAN/COMMIT. A cmd_valid held during that time is accepted only on return to IDLE. Inputs are sampled only at the accept edge.
- steal_pulse is high for exactly the one cycle following E9.
- Reset mid-SCAN/COMMIT aborts the command: no voice write, outputs return to reset values.
- busy = (state != IDLE), registered with the state.

## Test plan
- Reset then 8 note-ons, notes 60..67, divs 0x0100..0x0107, back-to-back valid -> voices 0..7 get them in order; voice_gate=0xFF; each update 9 cycles after its accept; no steal_pulse.
- With all 8 held, note-on note 70, div 0x0A00 -> voice 0 (age 7, oldest) gets div 0x0A00; steal_pulse one cycle; ages: v0=0, others +1.
- Note-off note 63 -> voice_gate bit 3 clears, voice_div[3] stays 0x0103. Next note-on note 80, div 0x0200 -> voice 3 (lowest free), no steal.
- Note-on note 65 (held on voice 5), div 0x0555 -> voice 5 retriggered with div 0x0555, age 0; no other voice changes div.
- Note-off note 99 (absent) -> no output change; cmd_ready returns after 9 cycles.
- Assert sys_rst 3 cycles after an accept -> all gates 0, divs 0, no commit; after release a new note-on lands in voice 0.
